regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
Parametrised successor to the 32x32 two-read-port register file. It generalises data width, depth and read-port count, and adds a per-register busy scoreboard used by the pipeline hazard unit. It sits in the decode stage of the processor. Writeback writes one register per cycle; decode reserves destination registers and reads operands with their busy status.

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
READ_PORTS, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy; 0 = register 0 is ordinary

Ports:
clock  in  1  system clock; all state updates on rising edge
ctrl_reset  in  1  asynchronous, active-high reset
ctrl_writeEn  in  1  write strobe
ctrl_writeReg  in  ADDR_WIDTH  write index
data_writeReg  in  DATA_WIDTH  write data
ctrl_reserveEn  in  1  mark ctrl_reserveReg busy (in-flight producer)
ctrl_reserveReg  in  ADDR_WIDTH  index to reserve
ctrl_readReg  in  READ_PORTS*ADDR_WIDTH  packed read indices; port p = bits [p*ADDR_WIDTH +: ADDR_WIDTH]
data_readReg  out  READ_PORTS*DATA_WIDTH  packed read data, same packing
busy_readReg  out  READ_PORTS  busy bit of the register addressed by each port
busy_count  out  ADDR_WIDTH+1  number of registers currently busy

Behaviour:
- Reset, asynchronous: all registers = 0 and all busy bits = 0. Therefore busy_count = 0, data_readReg = 0 and busy_readReg = 0 for any index. Reset dominates write and reserve in the same cycle. Deassertion takes effect at the next rising edge.
- Write: on rising edge with ctrl_writeEn=1, reg[ctrl_writeReg] <= data_writeReg and busy[ctrl_writeReg] <= 0.
- ZERO_REG=1: a write to index 0 is discarded and a reserve of index 0 is ignored. Reading index 0 returns 0 with busy 0.
- Reserve: on rising edge with ctrl_reserveEn=1, busy[ctrl_reserveReg] <= 1. Reserving an already-busy register leaves it busy, and the count is unchanged.
- Write and reserve to the same index in the same cycle: the data is stored and the register ends busy (the reserve wins, because a newer producer is in flight). busy_count is unchanged if the register was busy, and +1 if it was not.
- Write and reserve to different indices: both take effect in that edge.
- busy_count: registered, updated on the same edge as the busy bits. It always equals the popcount of the busy bits and never exceeds the depth (minus 1 when ZERO_REG=1).
- Reads: combinational from the current state, zero-cycle latency, independent per port. Any number of ports may address the same index.
- Write with ctrl_writeEn=0: no state change. Index and data inputs are don't-care.
- Read latency of a write without bypass: the new value is visible after the rising edge that commits it.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-through forwarding. When ctrl_writeEn=1 and a read port addresses ctrl_writeReg (and it is not the ZERO_REG=1 index 0), that port's data_readReg = data_writeReg combinationally in the same cycle. Its busy_readReg = ctrl_reserveEn && (ctrl_reserveReg == ctrl_writeReg). Other ports and all stored state are unaffected.
- Undefined: reads return stored state only, and the old value is visible until the write edge.
- busy_count is identical in both builds.

Test Plan:
1. Reset asserted for 2 cycles then released -> every index on every port reads 32'h00000000 with busy 0, and busy_count=0.
2. Write 32'h0000DEAD to indices 0..31 sequentially. Check each after its write edge, and check index+1 still 0 -> index 0 reads 0, indices 1..31 read 32'h0000DEAD. Repeat with ZERO_REG=0 -> index 0 reads 32'h0000DEAD.
3. Reserve r5 and r7, then read both on ports 0 and 1 -> busy_readReg=2'b11 and busy_count=2. Write r5=32'h12345678 -> port 0 data=32'h12345678 with busy 0, and busy_count=1.
4. Same-cycle write of r9=32'hCAFEF00D plus reserve of r9, with r9 initially free -> r9 reads 32'hCAFEF00D with busy=1, and busy_count increments by 1. Same-cycle reserve of r0 (ZERO_REG=1) -> busy_count unchanged.
5. Set r3=32'hAAAA0000, then in one cycle write r3=32'h5555FFFF while port 1 reads r3 before the edge -> with REGFILE_BYPASS_EN, 32'h5555FFFF; without it, 32'hAAAA0000.
6. Reserve r4 and write r6=32'h00000BEE, then assert ctrl_reset mid-cycle, asynchronously between edges -> outputs immediately read 0, busy_count=0, and the pending write and reserve have no effect.

Source files
------------

// File: rtl/regfile_param.sv
// ============================================================================
// Module   : regfile_param
// Purpose  : Parametrised decode-stage register file with a per-register
//            busy scoreboard for the pipeline hazard unit. Writeback writes
//            one register per cycle; decode reserves destination registers
//            and reads operands together with their busy status.
// Revision : 1.0 - initial release
//
// Ports
//   clock            in   system clock, all state updates on rising edge
//   ctrl_reset       in   asynchronous active-high reset
//   ctrl_writeEn     in   write strobe
//   ctrl_writeReg    in   write index
//   data_writeReg    in   write data
//   ctrl_reserveEn   in   mark ctrl_reserveReg busy
//   ctrl_reserveReg  in   index to reserve
//   ctrl_readReg     in   packed read indices, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   data_readReg     out  packed read data, same packing
//   busy_readReg     out  busy bit of the register addressed by each port
//   busy_count       out  number of registers currently busy
//
// Build option
//   REGFILE_BYPASS_EN  when defined, a read port addressing the register
//                      being written this cycle sees the write data (and the
//                      busy state that register will have after the edge).
// ============================================================================
`default_nettype none

module regfile_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                             clock,
  input  logic                             ctrl_reset,
  input  logic                             ctrl_writeEn,
  input  logic [ADDR_WIDTH-1:0]            ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0]            data_writeReg,
  input  logic                             ctrl_reserveEn,
  input  logic [ADDR_WIDTH-1:0]            ctrl_reserveReg,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] ctrl_readReg,
  output logic [READ_PORTS*DATA_WIDTH-1:0] data_readReg,
  output logic [READ_PORTS-1:0]            busy_readReg,
  output logic [ADDR_WIDTH:0]              busy_count
);

  localparam int DEPTH    = 2 ** ADDR_WIDTH;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  // Flattened view of the storage, assembled from the per-register
  // generate blocks below.
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_next;
  logic [ADDR_WIDTH:0]   count_next;

  // Accesses to the hardwired zero register are dropped here, so neither
  // the storage nor the scoreboard ever sees them.
  logic write_ok;
  logic reserve_ok;

  assign write_ok   = ctrl_writeEn   && !(HAS_ZERO && (ctrl_writeReg   == '0));
  assign reserve_ok = ctrl_reserveEn && !(HAS_ZERO && (ctrl_reserveReg == '0));

  // --------------------------------------------------------------------------
  // Scoreboard next state. The write clear is applied first and the reserve
  // set second, so a same-index write+reserve leaves the register busy: the
  // reservation belongs to a newer producer than the value being written.
  // --------------------------------------------------------------------------
  always_comb begin
    busy_next = busy;
    if (write_ok) begin
      busy_next[ctrl_writeReg] = 1'b0;
    end
    if (reserve_ok) begin
      busy_next[ctrl_reserveReg] = 1'b1;
    end
  end

  // The count is the popcount of the next busy vector, registered on the
  // same edge as the busy bits so the two can never disagree.
  always_comb begin
    count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_next = count_next + {{ADDR_WIDTH{1'b0}}, busy_next[i]};
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      busy_count <= '0;
    end else begin
      busy_count <= count_next;
    end
  end

  // --------------------------------------------------------------------------
  // Per-register storage and busy flag.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if (HAS_ZERO && (i == 0)) begin : g_zero
      assign regs[i] = '0;
      assign busy[i] = 1'b0;
    end else begin : g_store
      logic [DATA_WIDTH-1:0] value;
      logic                  busy_bit;

      always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
          value    <= '0;
          busy_bit <= 1'b0;
        end else begin
          if (write_ok && (ctrl_writeReg == ADDR_WIDTH'(i))) begin
            value <= data_writeReg;
          end
          busy_bit <= busy_next[i];
        end
      end

      assign regs[i] = value;
      assign busy[i] = busy_bit;
    end
  end

  // --------------------------------------------------------------------------
  // Read ports: combinational, zero latency, fully independent.
  // --------------------------------------------------------------------------
  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rbusy;

    assign idx = ctrl_readReg[p*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rdata = regs[idx];
      rbusy = busy[idx];
`ifdef REGFILE_BYPASS_EN
      // Forward the in-flight write. write_ok already excludes the zero
      // register; reset suppresses forwarding so outputs read zero at once.
      if (!ctrl_reset && write_ok && (idx == ctrl_writeReg)) begin
        rdata = data_writeReg;
        rbusy = ctrl_reserveEn && (ctrl_reserveReg == ctrl_writeReg);
      end
`endif
    end

    assign data_readReg[p*DATA_WIDTH +: DATA_WIDTH] = rdata;
    assign busy_readReg[p]                          = rbusy;
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_param.sv
// ============================================================================
// Module   : tb_regfile_param
// Purpose  : Self-checking bench for regfile_param. Two instances share the
//            write/reserve stimulus: A uses the defaults (ZERO_REG=1, two
//            read ports), B uses ZERO_REG=0 with three read ports. A
//            behavioural array model predicts every output on each falling
//            edge; directed sequences pin the model with literal values.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  wr = '0;
  logic [31:0] wd = '0;
  logic        re = 1'b0;
  logic [4:0]  rr = '0;
  logic [9:0]  rd_a = '0;
  logic [14:0] rd_b = '0;
  logic [63:0] dat_a;
  logic [1:0]  bsy_a;
  logic [5:0]  cnt_a;
  logic [95:0] dat_b;
  logic [2:0]  bsy_b;
  logic [5:0]  cnt_b;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  always #5 clock = ~clock;

  regfile_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_PORTS(2), .ZERO_REG(1)) dut_a (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .ctrl_writeEn(we), .ctrl_writeReg(wr), .data_writeReg(wd),
    .ctrl_reserveEn(re), .ctrl_reserveReg(rr),
    .ctrl_readReg(rd_a), .data_readReg(dat_a),
    .busy_readReg(bsy_a), .busy_count(cnt_a)
  );

  regfile_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_PORTS(3), .ZERO_REG(0)) dut_b (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .ctrl_writeEn(we), .ctrl_writeReg(wr), .data_writeReg(wd),
    .ctrl_reserveEn(re), .ctrl_reserveReg(rr),
    .ctrl_readReg(rd_b), .data_readReg(dat_b),
    .busy_readReg(bsy_b), .busy_count(cnt_b)
  );

  // ---------------- behavioural model (index 0 = instance A, 1 = B) --------
  logic [31:0] m_regs [2][32];
  bit          m_busy [2][32];

  always @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int k = 0; k < 2; k++)
        for (int j = 0; j < 32; j++) begin
          m_regs[k][j] <= '0;
          m_busy[k][j] <= 1'b0;
        end
    end else begin
      for (int k = 0; k < 2; k++) begin
        // Write first, reserve second: a reserve to the same index wins.
        if (we && !(k == 0 && wr == 5'd0)) begin
          m_regs[k][wr] <= wd;
          m_busy[k][wr] <= 1'b0;
        end
        if (re && !(k == 0 && rr == 5'd0))
          m_busy[k][rr] <= 1'b1;
      end
    end
  end

  function automatic logic [31:0] exp_data(int k, logic [4:0] idx);
    if (ctrl_reset) return 32'h0;
    if (k == 0 && idx == 5'd0) return 32'h0;
    if (BYP && we && idx == wr) return wd;
    return m_regs[k][idx];
  endfunction

  function automatic logic [31:0] exp_busy(int k, logic [4:0] idx);
    if (ctrl_reset) return 32'h0;
    if (k == 0 && idx == 5'd0) return 32'h0;
    if (BYP && we && idx == wr) return {31'h0, re && (rr == wr)};
    return {31'h0, m_busy[k][idx]};
  endfunction

  function automatic logic [31:0] exp_cnt(int k);
    int s = 0;
    for (int j = 0; j < 32; j++) s += int'(m_busy[k][j]);
    return 32'(s);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare against the model --------------------
  always @(negedge clock) begin
    if (run_cmp) begin
      for (int p = 0; p < 2; p++) begin
        check($sformatf("A.data[%0d]", p), dat_a[p*32 +: 32], exp_data(0, rd_a[p*5 +: 5]));
        check($sformatf("A.busy[%0d]", p), {31'h0, bsy_a[p]}, exp_busy(0, rd_a[p*5 +: 5]));
      end
      for (int p = 0; p < 3; p++) begin
        check($sformatf("B.data[%0d]", p), dat_b[p*32 +: 32], exp_data(1, rd_b[p*5 +: 5]));
        check($sformatf("B.busy[%0d]", p), {31'h0, bsy_b[p]}, exp_busy(1, rd_b[p*5 +: 5]));
      end
      check("A.count", {26'h0, cnt_a}, exp_cnt(0));
      check("B.count", {26'h0, cnt_b}, exp_cnt(1));
    end
  end

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    we = 1'b0;
    re = 1'b0;
  endtask

  // ---------------- directed sequences then random traffic -----------------
  initial begin
    #1 ctrl_reset = 1'b1;
    #1 run_cmp = 1'b1;
    cyc();
    cyc();
    ctrl_reset = 1'b0;
    cyc();

    // Reset state on every index and port.
    for (int i = 0; i < 32; i++) begin
      rd_a = {5'(i), 5'(i)};
      rd_b = {5'(i), 5'(i), 5'(i)};
      #1;
      check("rst.A.data0", dat_a[31:0], 32'h0);
      check("rst.A.data1", dat_a[63:32], 32'h0);
      check("rst.A.busy", {30'h0, bsy_a}, 32'h0);
      check("rst.B.data2", dat_b[95:64], 32'h0);
      cyc();
    end
    check("rst.A.count", {26'h0, cnt_a}, 32'h0);
    check("rst.B.count", {26'h0, cnt_b}, 32'h0);

    // Sequential fill with 0000DEAD; next index must still be zero.
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; wr = 5'(i); wd = 32'h0000DEAD;
      cyc();
      idle();
      rd_a = {5'(i + 1), 5'(i)};
      rd_b = {5'(i), 5'(i + 1), 5'(i)};
      #1;
      check("fill.A.this", dat_a[31:0], (i == 0) ? 32'h0 : 32'h0000DEAD);
      check("fill.B.this", dat_b[31:0], 32'h0000DEAD);
      if (i < 31) begin
        check("fill.A.next", dat_a[63:32], 32'h0);
        check("fill.B.next", dat_b[63:32], 32'h0);
      end
    end

    // Reserve r5 and r7, then retire r5.
    re = 1'b1; rr = 5'd5; cyc();
    rr = 5'd7; cyc();
    idle();
    rd_a = {5'd7, 5'd5};
    #1;
    check("rsv.A.busy", {30'h0, bsy_a}, 32'h3);
    check("rsv.A.count", {26'h0, cnt_a}, 32'd2);
    check("rsv.B.count", {26'h0, cnt_b}, 32'd2);
    we = 1'b1; wr = 5'd5; wd = 32'h12345678;
    cyc();
    idle();
    #1;
    check("wb.A.data0", dat_a[31:0], 32'h12345678);
    check("wb.A.busy0", {31'h0, bsy_a[0]}, 32'h0);
    check("wb.A.count", {26'h0, cnt_a}, 32'd1);

    // Same-cycle write and reserve of free r9.
    we = 1'b1; wr = 5'd9; wd = 32'hCAFEF00D; re = 1'b1; rr = 5'd9;
    cyc();
    idle();
    rd_a = {5'd7, 5'd9};
    #1;
    check("wr+rsv.A.data", dat_a[31:0], 32'hCAFEF00D);
    check("wr+rsv.A.busy", {31'h0, bsy_a[0]}, 32'h1);
    check("wr+rsv.A.count", {26'h0, cnt_a}, 32'd2);
    // Reserve r0: ignored on A, ordinary on B.
    re = 1'b1; rr = 5'd0;
    cyc();
    idle();
    rd_a = {5'd0, 5'd0};
    #1;
    check("rsv0.A.count", {26'h0, cnt_a}, 32'd2);
    check("rsv0.A.busy", {30'h0, bsy_a}, 32'h0);
    check("rsv0.B.count", {26'h0, cnt_b}, 32'd3);

    // Read-during-write of r3 on port 1.
    we = 1'b1; wr = 5'd3; wd = 32'hAAAA0000;
    cyc();
    wd = 32'h5555FFFF;
    rd_a = {5'd3, 5'd0};
    #1;
    check("rdw.A.data1", dat_a[63:32], BYP ? 32'h5555FFFF : 32'hAAAA0000);
    check("rdw.A.busy1", {31'h0, bsy_a[1]}, 32'h0);
    cyc();
    idle();
    #1;
    check("rdw.A.after", dat_a[63:32], 32'h5555FFFF);

    // Asynchronous reset between edges cancels a pending write and reserve.
    re = 1'b1; rr = 5'd4; we = 1'b1; wr = 5'd6; wd = 32'h00000BEE;
    rd_a = {5'd4, 5'd6};
    #1 ctrl_reset = 1'b1;
    #1;
    check("arst.A.data0", dat_a[31:0], 32'h0);
    check("arst.A.busy1", {31'h0, bsy_a[1]}, 32'h0);
    check("arst.A.count", {26'h0, cnt_a}, 32'h0);
    check("arst.B.count", {26'h0, cnt_b}, 32'h0);
    cyc();
    ctrl_reset = 1'b0;
    idle();
    cyc();
    #1;
    check("arst.A.r6", dat_a[31:0], 32'h0);
    check("arst.A.r4busy", {31'h0, bsy_a[1]}, 32'h0);
    check("arst.A.count2", {26'h0, cnt_a}, 32'h0);

    // Random traffic: alternate reserve-heavy and write-heavy phases, some
    // cycles confined to a few low indices to force collisions and r0 hits.
    for (int n = 0; n < 3000; n++) begin
      bit narrow;
      bit rsv_heavy;
      narrow    = ($urandom_range(0, 3) == 0);
      rsv_heavy = ((n / 250) % 2) == 0;
      we = ($urandom_range(0, 99) < (rsv_heavy ? 25 : 70));
      re = ($urandom_range(0, 99) < (rsv_heavy ? 75 : 25));
      wr = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      rr = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      wd = $urandom;
      rd_a = 10'($urandom);
      rd_b = 15'($urandom);
      if ($urandom_range(0, 3) == 0) rd_a[4:0] = wr;
      if ($urandom_range(0, 3) == 0) rd_b[9:5] = wr;
      ctrl_reset = ($urandom_range(0, 399) == 0);
      cyc();
    end
    ctrl_reset = 1'b0;
    idle();
    cyc();
    cyc();
    run_cmp = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
